id_fetch_buffer: RTL and testbench

- Parametrised instruction buffer between IF and the decode stage.
- Replaces the single-entry "hold instruction while stalled" register with a DEPTH-entry queue of {pc, inst} pairs.
- Absorbs the one-cycle inst_sram read latency and downstream decode stalls.
- Discards all buffered and in-flight fetches on a redirect.

---
 rtl/id_fetch_buffer_pkg.sv | 15 +
 rtl/id_fetch_buffer_if.sv | 30 +++
 rtl/id_fetch_buffer_fifo.sv | 56 +++++
 rtl/id_fetch_buffer.sv | 86 ++++++++
 tb/tb_id_fetch_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/id_fetch_buffer_pkg.sv
// id_fetch_buffer_pkg: shared sizes and the {pc, inst} entry type for the
// IF-to-ID fetch buffer.
package id_fetch_buffer_pkg;

    localparam int ID_FB_DEPTH  = 4;
    localparam int ID_FB_PC_W   = 32;
    localparam int ID_FB_INST_W = 32;
    localparam int ENTRY_W      = ID_FB_PC_W + ID_FB_INST_W;

    typedef struct packed {
        logic [ID_FB_PC_W-1:0]   pc;
        logic [ID_FB_INST_W-1:0] inst;
    } fb_entry_t;

endpackage

// File: rtl/id_fetch_buffer_if.sv
// id_fetch_buffer_if: fetch-side and decode-side handshake of the fetch buffer.
// The slave modport is the buffer; the master modport is the IF/ID environment.
interface id_fetch_buffer_if
    import id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH  = ID_FB_DEPTH,
    parameter int PC_W   = ID_FB_PC_W,
    parameter int INST_W = ID_FB_INST_W
);
    logic                       flush;
    logic                       if_valid;
    logic [PC_W-1:0]            if_pc;
    logic                       if_ready;
    logic [INST_W-1:0]          inst_sram_rdata;
    logic                       id_valid;
    logic [PC_W-1:0]            id_pc;
    logic [INST_W-1:0]          id_inst;
    logic                       id_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport slave (
        input  flush, if_valid, if_pc, inst_sram_rdata, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count
    );

    modport master (
        output flush, if_valid, if_pc, inst_sram_rdata, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count
    );
endinterface

// File: rtl/id_fetch_buffer_fifo.sv
// fb_fifo: generic DEPTH x WIDTH synchronous FIFO with clear, occupancy count
// and a combinational head. Full/empty come from the count, never from
// pointer equality. Asynchronous active-low reset.
module fb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage, pointers and count; clear beats push/pop, pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/id_fetch_buffer.sv
// id_fetch_buffer: DEPTH-entry {pc, inst} queue between IF and decode.
// Holds credit, in-flight (pending) tracking, flush and optional bypass; the
// storage lives in fb_fifo.
// Optional feature macro: ID_FETCH_BUFFER_BYPASS_EN (empty-queue bypass, T+1).
module id_fetch_buffer
    import id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH  = ID_FB_DEPTH,
    parameter int PC_W   = ID_FB_PC_W,
    parameter int INST_W = ID_FB_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    id_fetch_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = PC_W + INST_W;

    logic            r_pend_vld;
    logic [PC_W-1:0] r_pend_pc;

    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic [CW:0]     w_credit;
    logic            w_ready;
    logic            w_accept;
    logic            w_resp;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // A slot is reserved for every in-flight fetch so its word always fits
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_pend_vld};
    assign w_ready  = rst & ~bus.flush & (w_credit < (CW+1)'(DEPTH));
    assign w_accept = bus.if_valid & w_ready;
    assign w_resp   = r_pend_vld & ~bus.flush;
    assign w_empty  = (w_count == '0);
    assign w_pop    = ~w_empty & bus.id_ready;

`ifdef ID_FETCH_BUFFER_BYPASS_EN
    logic w_bypass;

    assign w_bypass     = w_empty & w_resp;
    assign w_push       = w_resp & ~(w_bypass & bus.id_ready);
    assign bus.id_valid = ~w_empty | w_bypass;
    assign bus.id_pc    = w_bypass ? r_pend_pc : w_head[EW-1:INST_W];
    assign bus.id_inst  = w_bypass ? bus.inst_sram_rdata : w_head[INST_W-1:0];
`else
    assign w_push       = w_resp;
    assign bus.id_valid = ~w_empty;
    assign bus.id_pc    = w_head[EW-1:INST_W];
    assign bus.id_inst  = w_head[INST_W-1:0];
`endif

    assign bus.if_ready = w_ready;
    assign bus.count    = w_count;

    // Pending fetch: set on accept, dropped on flush, re-armed back-to-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
        end else if (bus.flush) begin
            r_pend_vld <= 1'b0;
        end else begin
            r_pend_vld <= w_accept;
            if (w_accept) begin
                r_pend_pc <= bus.if_pc;
            end
        end
    end

    fb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .i_wdata ({r_pend_pc, bus.inst_sram_rdata}),
        .o_count (w_count),
        .o_head  (w_head)
    );
endmodule

// File: tb/tb_id_fetch_buffer.sv
// tb_id_fetch_buffer: directed and random stimulus for id_fetch_buffer,
// checked against a queue-based model of the buffer's behaviour.
module tb_id_fetch_buffer;
    import id_fetch_buffer_pkg::*;

    localparam int DEPTH = 4;
`ifdef ID_FETCH_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;

    id_fetch_buffer_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus ();

    id_fetch_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    fb_entry_t   mq[$];
    bit          mPend = 1'b0;
    logic [31:0] mPendPc = '0;
    logic [31:0] mPendInst = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge
    task automatic applyStimulus(input bit fl, input bit iv, input logic [31:0] pc,
                                 input logic [31:0] inst, input bit ir, output bit acc);
        bit        expReady;
        bit        byp;
        bit        expValid;
        fb_entry_t head;
        @(negedge clk);
        bus.flush           = fl;
        bus.if_valid        = iv;
        bus.if_pc           = pc;
        bus.id_ready        = ir;
        bus.inst_sram_rdata = mPend ? mPendInst : $urandom;
        #1;
        expReady = rst && !fl && ((mq.size() + int'(mPend)) < DEPTH);
        byp      = BYPASS && (mq.size() == 0) && mPend && !fl;
        expValid = (mq.size() != 0) || byp;
        if (mq.size() != 0) head = mq[0];
        else                head = '{pc: mPendPc, inst: mPendInst};
        checkOutput("if_ready", 64'(bus.if_ready), 64'(expReady));
        checkOutput("count", 64'(bus.count), 64'(mq.size()));
        checkOutput("id_valid", 64'(bus.id_valid), 64'(expValid));
        if (expValid) begin
            checkOutput("id_pc", 64'(bus.id_pc), 64'(head.pc));
            checkOutput("id_inst", 64'(bus.id_inst), 64'(head.inst));
        end
        acc = iv && expReady;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mPend = 1'b0;
        end else begin
            if (expValid && ir && !byp) void'(mq.pop_front());
            if (mPend && !(byp && ir)) mq.push_back('{pc: mPendPc, inst: mPendInst});
            mPend = acc;
            if (acc) begin
                mPendPc   = pc;
                mPendInst = inst;
            end
        end
    endtask

    initial begin
        bit          acc;
        logic [31:0] pc;
        logic [31:0] firstPc;

        rst                 = 1'b0;
        bus.flush           = 1'b0;
        bus.if_valid        = 1'b0;
        bus.if_pc           = '0;
        bus.inst_sram_rdata = '0;
        bus.id_ready        = 1'b0;
        #3;
        checkOutput("reset_id_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("reset_count", 64'(bus.count), 64'd0);
        checkOutput("reset_id_pc", 64'(bus.id_pc), 64'd0);
        checkOutput("reset_id_inst", 64'(bus.id_inst), 64'd0);
        checkOutput("reset_if_ready", 64'(bus.if_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");

        // Steady stream from the reset vector with decode always ready
        pc = 32'hBFC0_0000;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, i < 3, pc, $urandom, 1'b1, acc);
            if (acc) pc = pc + 32'd4;
            #1;
            checkOutput("stream_count_le1", 64'(bus.count <= 1), 64'd1);
        end

        // Decode stall: buffer fills to DEPTH and refuses further fetches
        pc      = 32'h0000_1000;
        firstPc = pc;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, pc, $urandom, 1'b0, acc);
            if (acc) pc = pc + 32'd4;
        end
        #1;
        checkOutput("fill_count", 64'(bus.count), 64'(DEPTH));
        checkOutput("fill_if_ready", 64'(bus.if_ready), 64'd0);
        checkOutput("fill_head_pc", 64'(bus.id_pc), 64'(firstPc));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Flush kills an in-flight response; the next fetch lands at the head
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h2402_0001, 1'b1, acc);
        applyStimulus(1'b1, 1'b1, 32'h104, 32'h0, 1'b1, acc);
        #1;
        checkOutput("flush_count", 64'(bus.count), 64'd0);
        checkOutput("flush_id_valid", 64'(bus.id_valid), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h3C1D_0000, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
        #1;
        checkOutput("after_flush_head_pc", 64'(bus.id_pc), 64'h200);
        checkOutput("after_flush_head_inst", 64'(bus.id_inst), 64'h3C1D_0000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Pointer wrap with decode toggling ready every cycle
        pc = 32'h0000_2000;
        for (int i = 0; i < 6 * DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, pc, $urandom, (i % 2) == 0, acc);
            if (acc) pc = pc + 32'd4;
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Bypass path: empty queue, decode ready, response consumed at T+1
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h2408_0040, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);
        #1;
        checkOutput("bypass_ready_count", 64'(bus.count), BYPASS ? 64'd0 : 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h2408_0041, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
        #1;
        checkOutput("bypass_stall_count", 64'(bus.count), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                          $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Asynchronous reset mid-stream with three entries buffered
        pc = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, pc, $urandom, 1'b0, acc);
            pc = pc + 32'd4;
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
        @(negedge clk);
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b0;
        #1;
        checkOutput("pre_reset_count", 64'(bus.count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_id_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("async_count", 64'(bus.count), 64'd0);
        checkOutput("async_if_ready", 64'(bus.if_ready), 64'd0);
        checkOutput("async_id_pc", 64'(bus.id_pc), 64'd0);
        mq.delete();
        mPend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, pc, $urandom, 1'b1, acc);
            if (acc) pc = pc + 32'd4;
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
